// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial ripple adder: captures two N-bit operands plus carry-in, then
// resolves one sum bit per clock (LSB first) and publishes sum/cout on completion.
module bit_serial_add_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  sum_sr_q, sum_sr_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          s_c;
  logic          maj_c;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  // Full-adder slice on the current LSBs
  assign s_c   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign maj_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = {1'b0, a_sr_q[N-1:1]};
        b_sr_d   = {1'b0, b_sr_q[N-1:1]};
        sum_sr_d = {s_c, sum_sr_q[N-1:1]};
        carry_d  = maj_c;
        if (cnt_q == CW'(N - 1)) begin
          // Counter parks at N-1; it is re-armed on the next acceptance
          sum_d   = {s_c, sum_sr_q[N-1:1]};
          cout_d  = maj_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Bench for bit_serial_add_ctrl (N=8): scenario tasks plus a done-driven
// scoreboard that also watches sum/cout stability between completions.
module tb_bit_serial_add_ctrl;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         ready;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int unsigned  n_checks;
  int unsigned  n_fail;
  logic [N:0]   exp_q[$];
  logic         armed;
  logic [N:0]   last_res;

  bit_serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pop on every done, otherwise results must hold steady
  always @(negedge clk) begin
    if (armed) begin
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: got sum=%h cout=%b with no pending result", sum, cout);
        end else begin
          logic [N:0] e;
          e = exp_q.pop_front();
          if ({cout, sum} !== e) begin
            n_fail++;
            $display("FAIL sb_result: got cout=%b sum=%h, expected cout=%b sum=%h",
                     cout, sum, e[N], e[N-1:0]);
          end
        end
        last_res = {cout, sum};
      end else begin
        n_checks++;
        if ({cout, sum} !== last_res) begin
          n_fail++;
          $display("FAIL sb_hold: got cout=%b sum=%h without done, expected held cout=%b sum=%h",
                   cout, sum, last_res[N], last_res[N-1:0]);
        end
      end
      if (!rst) last_res = '0;
    end
  end

  // Drive one addition from IDLE and check the cycle-accurate handshake.
  // Entered and left at posedge+1.
  task automatic run_add(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ready_pre: got ready=%b, expected 1", ready);
    end
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back((N+1)'(ta) + (N+1)'(tb_v) + (N+1)'(tc));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== (k == int'(N)) || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL add_latency: edge %0d got done=%b ready=%b, expected done=%b ready=0",
                 k, done, ready, (k == int'(N)));
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_return_idle: got ready=%b done=%b, expected ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b done=%b sum=%h cout=%b, expected 1 0 00 0",
               ready, done, sum, cout);
    end
    last_res = '0;
    armed = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_add(8'hAB, 8'h01, 1'b0);
    n_checks++;
    if (sum !== 8'hAC || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got sum=%h cout=%b, expected sum=ac cout=0", sum, cout);
    end
  endtask

  task automatic test_carry();
    run_add(8'hFF, 8'h01, 1'b0);
    n_checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_wrap: got sum=%h cout=%b, expected sum=00 cout=1", sum, cout);
    end
    run_add(8'hFF, 8'hFF, 1'b1);
    n_checks++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_max: got sum=%h cout=%b, expected sum=ff cout=1", sum, cout);
    end
  endtask

  // start pulses during SHIFT and DONE must be ignored
  task automatic test_ignore_busy();
    int dones;
    dones = 0;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h030);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= int'(N) + 2; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start = (k == 3 || k == int'(N));
      a = start ? 8'h55 : 8'h10;
      if (k <= int'(N)) begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_ready: edge %0d got ready=%b, expected 0", k, ready);
        end
      end else begin
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_idle: edge %0d got ready=%b done=%b, expected 1 0", k, ready, done);
        end
      end
    end
    n_checks++;
    if (dones != 1 || sum !== 8'h30 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got dones=%0d sum=%h cout=%b, expected 1 30 0", dones, sum, cout);
    end
  endtask

  task automatic test_reset_midway();
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got ready=%b done=%b sum=%h cout=%b, expected 1 0 00 0",
               ready, done, sum, cout);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midreset_quiet: got done=%b ready=%b, expected 0 1", done, ready);
      end
    end
    run_add(8'h02, 8'h03, 1'b0);
    n_checks++;
    if (sum !== 8'h05 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_fresh: got sum=%h cout=%b, expected 05 0", sum, cout);
    end
  endtask

  // start held high: one acceptance per IDLE visit, N+2 cycles apart
  task automatic test_back_to_back();
    int dones;
    dones = 0;
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back(9'h080);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 29) start = 1'b0;
      if (done) dones++;
      n_checks++;
      if (done !== ((k % (int'(N) + 2)) == int'(N))) begin
        n_fail++;
        $display("FAIL b2b_spacing: edge %0d got done=%b, expected %b",
                 k, done, ((k % (int'(N) + 2)) == int'(N)));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dones != 3 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_count: got dones=%0d ready=%b, expected 3 1", dones, ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_add(N'($urandom), N'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    last_res = '0;
    rst      = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    test_reset();
    test_basic();
    test_carry();
    test_ignore_busy();
    test_reset_midway();
    test_back_to_back();
    test_random();

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
